systolic_array_nxn: RTL and testbench
=====================================

# systolic_array_nxn

Parametrised weight-stationary N×N systolic matrix-vector engine. It is the successor to the fixed 2×2 array in the compute path between the unified buffer and the accumulator/activation stage. Input skewing and output deskewing are internal, so callers present and receive whole aligned vectors, one per cycle. Weights are double-buffered per PE (shadow/active), and the active column count is runtime-configurable.

## Interface
- `N`, 4, array dimension: rows = columns = N, N ≥ 1.
- `DW`, 16, data/weight/psum width, signed fixed-point.
- `FRAC`, 8, fractional bits (Q(DW-FRAC).FRAC).
- `clk`  in  1  clock; the block has one clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_data`  in  N*DW  input vector; slice r (bits r*DW +: DW) feeds row r.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `switch_in`  in  1  sampled with `in_data`; swaps shadow→active weights for this and later vectors.
- `weight_in`  in  N*DW  slice c feeds the top of column c's shadow shift chain.
- `accept_w`  in  N  bit c shifts column c's shadow chain this cycle.
- `col_size_in`  in  16  number of active columns.
- `col_size_valid_in`  in  1  load `col_size_in`.
- `out_data`  out  N*DW  result vector; slice c = column c sum.
- `out_valid`  out  1  `out_data` valid.
- `busy`  out  1  at least one valid vector is in flight.

## Operation
- PE(r,c) holds `shadow` and `active` weights and computes `psum_out = psum_in + ((a × w) >>> FRAC)`.
  - The product is a full 2DW-bit signed value, arithmetic-shifted, then truncated to DW bits.
  - The sum wraps modulo 2^DW.
  - `psum_in` is 0 for row 0.
- The input (`a`), valid and switch signals are registered per PE and pass right along the row. Psum is registered and passes down the column.
- Switch wave: column 0 passes the switch downward, and each row passes it rightward. At every PE it arrives on the same cycle as the vector it was sampled with.
  - On arrival, the PE uses `w = shadow` for that MAC and copies shadow→active.
  - Otherwise `w = active`.
- Input stage: all rows are registered once. Row r (data, valid, switch) is then delayed by r further cycles. Row 0 alone drives the switch/valid chain.
- Output stage: column c's bottom-PE psum is delayed by N-1-c cycles, so all columns leave on the same cycle.
  - `out_data` slice c is forced to 0 when column-mask bit c is clear.
  - Masked-off PEs do not update psum_out; they hold 0.
- Column mask:
  - `col_size_valid_in` loads `mask = (1<<col_size_in)-1` on the next edge. Any value ≥ N gives all ones.
  - The mask is applied to each PE and to each output slice on the cycle it is used. Changing it mid-stream affects only outputs from that cycle onward.
- Weight load, on each `accept_w[c]` cycle:
  - shadow(0,c) ← `weight_in[c]`, and shadow(r,c) ← shadow(r-1,c).
  - After exactly N accepts, shadow(r,c) holds the value presented at accept N-1-r.
  - Loading is legal while computing.
  - If a shift and a switch arrival coincide at a PE, active takes the pre-shift shadow value.
- `busy`: an in-flight counter.
  - +1 on `in_valid`, −1 on `out_valid`, both in the same cycle → unchanged.
  - `busy = (count != 0)`. The counter width is clog2(2N+1)+1.
- `in_valid` = 0 vectors still propagate data but produce `out_valid` = 0. A `switch_in` sampled with `in_valid` = 0 is still honoured.

## Timing
- Latency: vector sampled at edge 0 → `out_valid`/`out_data` registered and visible after edge 2N (N=2: 4 cycles; N=1: 2 cycles).
- Throughput: one vector per cycle, with no stall and no backpressure. The consumer must always accept.
- `col_size` takes effect 1 cycle after `col_size_valid_in`.
- Reset values:
  - `out_data` = 0, `out_valid` = 0, `busy` = 0.
  - All weights, psums, pipes and the counter are 0.
  - `mask` = 0, so all columns are disabled.
- Reset mid-operation: all in-flight vectors are discarded. Nothing is emitted after reset deasserts until a new `in_valid` has been through 2N cycles.

## Configuration
- `SYSTOLIC_SAT_EN` defined: the shifted product is clamped to [−2^(DW-1), 2^(DW-1)−1] before the add, and the add saturates to the same range.
- `SYSTOLIC_SAT_EN` undefined: truncate and wrap as in Operation.

## Test plan
All tests use N=2, DW=16, FRAC=8.
- Reset, col_size=2, load identity (column 0 shadow gets 0x0000 then 0x0100; column 1 gets 0x0100 then 0x0000), switch with in=(0x0200,0x0300) → 4 cycles later `out_valid`=1, out=(0x0200,0x0300).
- Same weights, col_size=1 → out=(0x0200,0x0000); col_size=7 → both columns active.
- All weights 0x0100, 4 back-to-back vectors → 4 consecutive `out_valid` cycles. Each column equals row0+row1, and `busy` falls the cycle after the last output.
- Load W2=0x0200 into shadow while streaming with W1=0x0100 active, assert switch on vector 3 → vectors 1–2 use W1 and vectors 3+ use W2 in every column.
- in=(0x7F00,0x7F00), weights 0x0100 → wrap: 0xFE00. With `SYSTOLIC_SAT_EN`: 0x7FFF.
- Assert `rst` for 1 cycle with 3 vectors in flight → no `out_valid` afterwards, `busy`=0, and the mask is cleared.

Source files
------------

// File: rtl/systolic_array_nxn.sv
// systolic_array_nxn: weight-stationary NxN matrix-vector engine with internal skew/deskew.
// Define SYSTOLIC_SAT_EN to saturate the product and accumulation instead of wrapping.
module systolic_array_nxn #(
  parameter int N    = 4,
  parameter int DW   = 16,
  parameter int FRAC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*DW-1:0] in_data,
  input  logic            in_valid,
  input  logic            switch_in,
  input  logic [N*DW-1:0] weight_in,
  input  logic [N-1:0]    accept_w,
  input  logic [15:0]     col_size_in,
  input  logic            col_size_valid_in,
  output logic [N*DW-1:0] out_data,
  output logic            out_valid,
  output logic            busy
);
  localparam int CW = $clog2(2*N+1) + 1;

  function automatic logic signed [DW-1:0] mac(input logic signed [DW-1:0] a, w, p);
    logic signed [2*DW-1:0] prod;
`ifdef SYSTOLIC_SAT_EN
    logic signed [DW-1:0] t;
    logic signed [DW:0] s;
`endif
    prod = (2*DW)'(a) * (2*DW)'(w);
    prod = prod >>> FRAC;
`ifdef SYSTOLIC_SAT_EN
    t = (&prod[2*DW-1:DW-1] || ~|prod[2*DW-1:DW-1]) ? prod[DW-1:0]
      : {prod[2*DW-1], {(DW-1){~prod[2*DW-1]}}};
    s = {p[DW-1], p} + {t[DW-1], t};
    return (s[DW] != s[DW-1]) ? {s[DW], {(DW-1){~s[DW]}}} : s[DW-1:0];
`else
    return p + DW'(prod);
`endif
  endfunction

  logic [N*DW-1:0] in_q;
  logic            in_v_q, in_s_q;
  logic [DW-1:0]   row_a [N];
  logic [DW-1:0]   a_q [N][N];
  logic [DW-1:0]   p_q [N][N];
  logic [DW-1:0]   sh_q [N][N];
  logic            v_q [N][N];
  logic            s_q [N][N];
  logic [DW-1:0]   col_out [N];
  logic [N-1:0]    mask;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q   <= '0;
      in_v_q <= 1'b0;
      in_s_q <= 1'b0;
    end else begin
      in_q   <= in_data;
      in_v_q <= in_valid;
      in_s_q <= switch_in;
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    if (r == 0) begin : g_skew
      assign row_a[0] = in_q[DW-1:0];
    end else begin : g_skew
      logic [DW-1:0] d [r];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < r; k++) d[k] <= '0;
        end else begin
          d[0] <= in_q[r*DW +: DW];
          for (int k = 1; k < r; k++) d[k] <= d[k-1];
        end
      end
      assign row_a[r] = d[r-1];
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_pr
    for (genvar c = 0; c < N; c++) begin : g_pc
      logic [DW-1:0] a_in, p_in, sh_in, act;
      logic          s_in, v_in;
      // the switch/valid wave runs down column 0, then right along each row
      if (c > 0) begin : g_src
        assign a_in = a_q[r][c-1];
        assign s_in = s_q[r][c-1];
        assign v_in = v_q[r][c-1];
      end else if (r > 0) begin : g_src
        assign a_in = row_a[r];
        assign s_in = s_q[r-1][0];
        assign v_in = v_q[r-1][0];
      end else begin : g_src
        assign a_in = row_a[0];
        assign s_in = in_s_q;
        assign v_in = in_v_q;
      end
      if (r > 0) begin : g_top
        assign p_in  = p_q[r-1][c];
        assign sh_in = sh_q[r-1][c];
      end else begin : g_top
        assign p_in  = '0;
        assign sh_in = weight_in[c*DW +: DW];
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q[r][c]  <= '0;
          p_q[r][c]  <= '0;
          sh_q[r][c] <= '0;
          act        <= '0;
          v_q[r][c]  <= 1'b0;
          s_q[r][c]  <= 1'b0;
        end else begin
          a_q[r][c] <= a_in;
          v_q[r][c] <= v_in;
          s_q[r][c] <= s_in;
          p_q[r][c] <= mask[c] ? mac(a_in, s_in ? sh_q[r][c] : act, p_in) : '0;
          if (accept_w[c]) sh_q[r][c] <= sh_in;
          if (s_in) act <= sh_q[r][c];
        end
      end
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_col
    localparam int D = N - 1 - c;
    if (D == 0) begin : g_dsk
      assign col_out[c] = p_q[N-1][c];
    end else begin : g_dsk
      logic [DW-1:0] d [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < D; k++) d[k] <= '0;
        end else begin
          d[0] <= p_q[N-1][c];
          for (int k = 1; k < D; k++) d[k] <= d[k-1];
        end
      end
      assign col_out[c] = d[D-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      cnt       <= '0;
      mask      <= '0;
    end else begin
      for (int c = 0; c < N; c++) out_data[c*DW +: DW] <= mask[c] ? col_out[c] : '0;
      out_valid <= v_q[N-1][N-1];
      cnt       <= cnt + CW'(in_valid) - CW'(out_valid);
      if (col_size_valid_in)
        mask <= (col_size_in >= 16'(N)) ? '1 : N'((32'd1 << col_size_in) - 32'd1);
    end
  end

  assign busy = (cnt != '0);
endmodule

// File: tb/tb_systolic_array_nxn.sv
// tb_systolic_array_nxn: directed checks of the 2x2 configuration against hand-computed results.
module tb_systolic_array_nxn;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic [31:0] weight_in = '0;
  logic        in_valid = 1'b0;
  logic        switch_in = 1'b0;
  logic [1:0]  accept_w = '0;
  logic [15:0] col_size_in = '0;
  logic        col_size_valid_in = 1'b0;
  logic [31:0] out_data;
  logic        out_valid, busy;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] vec [4];
  logic [31:0] exp_v [4];
  logic [3:0]  sw_at, acc_at;
  int          seen;

  systolic_array_nxn #(.N(2), .DW(16), .FRAC(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .switch_in(switch_in),
    .weight_in(weight_in), .accept_w(accept_w), .col_size_in(col_size_in),
    .col_size_valid_in(col_size_valid_in), .out_data(out_data), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_cs(input logic [15:0] n);
    col_size_in = n;
    col_size_valid_in = 1'b1;
    tick;
    col_size_valid_in = 1'b0;
  endtask

  task automatic load2(input logic [31:0] w_first, input logic [31:0] w_second);
    accept_w = 2'b11;
    weight_in = w_first;
    tick;
    weight_in = w_second;
    tick;
    accept_w = '0;
    weight_in = '0;
  endtask

  task automatic single(input string tag, input logic [31:0] d, input logic s, input logic [31:0] exp);
    in_data = d;
    in_valid = 1'b1;
    switch_in = s;
    tick;
    in_data = '0;
    in_valid = 1'b0;
    switch_in = 1'b0;
    check({tag, "_busy"}, busy, 1);
    repeat (3) tick;
    check({tag, "_early"}, out_valid, 0);
    tick;
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_data"}, out_data, exp);
    tick;
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic stream(input string tag, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      in_data = vec[i];
      in_valid = 1'b1;
      switch_in = sw_at[i];
      accept_w = acc_at[i] ? 2'b11 : 2'b00;
      weight_in = w;
      tick;
    end
    in_data = '0;
    in_valid = 1'b0;
    switch_in = 1'b0;
    accept_w = '0;
    weight_in = '0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check($sformatf("%s_vld%0d", tag, i), out_valid, 1);
      check($sformatf("%s_data%0d", tag, i), out_data, exp_v[i]);
    end
    check({tag, "_busy_last"}, busy, 1);
    tick;
    check({tag, "_vld_end"}, out_valid, 0);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    repeat (2) tick;
    rst = 1'b0;
    check("rst_vld", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);

    set_cs(2);
    load2(32'h0100_0000, 32'h0000_0100);
    single("ident", 32'h0300_0200, 1'b1, 32'h0300_0200);

    set_cs(1);
    single("cs1", 32'h0300_0200, 1'b0, 32'h0000_0200);
    set_cs(7);
    single("cs7", 32'h0300_0200, 1'b0, 32'h0300_0200);

    load2(32'h0100_0100, 32'h0100_0100);
    vec   = '{32'h0200_0100, 32'h0040_0080, 32'h0300_FF00, 32'h0001_0010};
    exp_v = '{32'h0300_0300, 32'h00C0_00C0, 32'h0200_0200, 32'h0011_0011};
    sw_at = 4'b0001;
    acc_at = 4'b0000;
    stream("b2b", 32'h0);

    vec   = '{32'h0100_0100, 32'h0020_0040, 32'h0100_0100, 32'h0020_0030};
    exp_v = '{32'h0200_0200, 32'h0060_0060, 32'h0400_0400, 32'h00A0_00A0};
    sw_at = 4'b0100;
    acc_at = 4'b0011;
    stream("dbuf", 32'h0200_0200);

    load2(32'h0100_0100, 32'h0100_0100);
`ifdef SYSTOLIC_SAT_EN
    single("ovf", 32'h7F00_7F00, 1'b1, 32'h7FFF_7FFF);
`else
    single("ovf", 32'h7F00_7F00, 1'b1, 32'hFE00_FE00);
`endif

    load2(32'h0180_0180, 32'h0180_0180);
    single("floor", 32'hFFFF_0001, 1'b1, 32'hFFFF_FFFF);

    for (int i = 0; i < 3; i++) begin
      in_data = 32'h0100_0100;
      in_valid = 1'b1;
      tick;
    end
    in_valid = 1'b0;
    in_data = '0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_vld", out_valid, 0);
    seen = 0;
    repeat (8) begin
      tick;
      if (out_valid) seen++;
    end
    check("mid_rst_no_out", seen, 0);
    load2(32'h0100_0100, 32'h0100_0100);
    single("rst_mask", 32'h0100_0100, 1'b1, 32'h0000_0000);
    set_cs(2);
    single("post_rst", 32'h0100_0100, 1'b0, 32'h0200_0200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
